// File: rtl/tetris_pkg.sv
// Playfield geometry and row-clear controller state encoding shared by the
// row-clear datapath, its bus interface and the bench.
package tetris_pkg;

    localparam int BOARD_ROWS = 20;
    localparam int BOARD_COLS = 10;
    localparam int ROW_W      = 7;
    localparam int CNT_W      = 4;
    localparam int LINES_W    = 16;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        FILL,
        NOTIFY,
        DONE
    } state_e;

endpackage

// File: rtl/row_clear_ctrl_if.sv
// Lock handshake, board row port and renderer handshake of the row-clear controller.
interface row_clear_ctrl_if #(
    parameter int BOARD_COLS = tetris_pkg::BOARD_COLS
);
    import tetris_pkg::*;

    logic                  Lock_valid;
    logic                  Lock_ready;
    logic                  Done;
    logic [ROW_W-1:0]      Board_raddr;
    logic [BOARD_COLS-1:0] Board_rdata;
    logic                  Board_we;
    logic [ROW_W-1:0]      Board_waddr;
    logic [BOARD_COLS-1:0] Board_wdata;
    logic                  Clear_row;
    logic [ROW_W-1:0]      Row_to_clear;
    logic [CNT_W-1:0]      Num_rows_to_clear;
    logic                  Clear_ack;

    modport master (
        input  Lock_valid, Board_rdata, Clear_ack,
        output Lock_ready, Done, Board_raddr, Board_we, Board_waddr, Board_wdata,
               Clear_row, Row_to_clear, Num_rows_to_clear
    );

    modport slave (
        output Lock_valid, Board_rdata, Clear_ack,
        input  Lock_ready, Done, Board_raddr, Board_we, Board_waddr, Board_wdata,
               Clear_row, Row_to_clear, Num_rows_to_clear
    );

endinterface

// File: rtl/row_full_detect.sv
// A row is full when every cell is occupied.
module row_full_detect #(
    parameter int BOARD_COLS = tetris_pkg::BOARD_COLS
) (
    input  logic [BOARD_COLS-1:0] row_i,
    output logic                  full_o
);

    assign full_o = &row_i;

endmodule

// File: rtl/row_clear_ctrl.sv
// Scans the board bottom-up after each lock, compacts surviving rows downward,
// zero-fills the vacated top rows and hands the result to the renderer.
module row_clear_ctrl #(
    parameter int BOARD_ROWS = tetris_pkg::BOARD_ROWS,
    parameter int BOARD_COLS = tetris_pkg::BOARD_COLS
) (
    input  logic                           Clk,
    input  logic                           Reset_n,
    row_clear_ctrl_if.master               bus,
    output logic [tetris_pkg::LINES_W-1:0] Lines_total
);
    import tetris_pkg::*;

    localparam logic [ROW_W-1:0] ROWS_IDX = ROW_W'(BOARD_ROWS);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(BOARD_ROWS - 1);

    state_e                state_q, state_d;
    logic [ROW_W-1:0]      cyc_q, cyc_d;
    logic [ROW_W-1:0]      wr_q, wr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ROW_W-1:0]      row_clr_q, row_clr_d;
    logic [LINES_W-1:0]    lines_q, lines_d;

    logic                  row_full;
    logic                  data_vld;
    logic [ROW_W-1:0]      data_row;
    logic [ROW_W-1:0]      raddr;
    logic                  we_raw;
    logic [ROW_W-1:0]      waddr;
    logic [BOARD_COLS-1:0] wdata;

    function automatic logic [LINES_W-1:0] sat_add(input logic [LINES_W-1:0] a,
                                                   input logic [CNT_W-1:0]   b);
        logic [LINES_W:0] s;
        s = {1'b0, a} + (LINES_W + 1)'(b);
        return s[LINES_W] ? '1 : s[LINES_W-1:0];
    endfunction

    row_full_detect #(.BOARD_COLS(BOARD_COLS)) u_full (
        .row_i  (bus.Board_rdata),
        .full_o (row_full)
    );

    // cyc_q counts SCAN cycles: reads go out for 0..ROWS-1, data returns for 1..ROWS.
    assign data_vld = (state_q == SCAN) && (cyc_q != '0);
    assign data_row = ROWS_IDX - cyc_q;

    always_comb begin
        state_d   = state_q;
        cyc_d     = cyc_q;
        wr_d      = wr_q;
        cnt_d     = cnt_q;
        row_clr_d = row_clr_q;
        lines_d   = lines_q;
        raddr     = '0;
        we_raw    = 1'b0;
        waddr     = '0;
        wdata     = '0;
        case (state_q)
            IDLE: begin
                if (bus.Lock_valid) begin
                    state_d   = SCAN;
                    cyc_d     = '0;
                    wr_d      = LAST_ROW;
                    cnt_d     = '0;
                    row_clr_d = '0;
                end
            end
            SCAN: begin
                if (cyc_q < ROWS_IDX) raddr = LAST_ROW - cyc_q;
                cyc_d = cyc_q + ROW_W'(1);
                if (data_vld) begin
                    if (row_full) begin
                        if (cnt_q == '0) row_clr_d = data_row;
                        cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
                    end else begin
                        we_raw = 1'b1;
                        waddr  = wr_q;
                        wdata  = bus.Board_rdata;
                        if (wr_q != '0) wr_d = wr_q - ROW_W'(1);
                    end
                end
                if (cyc_q == ROWS_IDX) begin
                    cyc_d   = '0;
                    state_d = (cnt_d == '0) ? DONE : FILL;
                end
            end
            FILL: begin
                // wr_q already points at the highest vacated row (count-1).
                we_raw = 1'b1;
                waddr  = wr_q;
                if (wr_q == '0) begin
                    state_d = NOTIFY;
                    lines_d = sat_add(lines_q, cnt_q);
                end else begin
                    wr_d = wr_q - ROW_W'(1);
                end
            end
            NOTIFY: begin
                if (bus.Clear_ack) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q   <= IDLE;
            cyc_q     <= '0;
            wr_q      <= '0;
            cnt_q     <= '0;
            row_clr_q <= '0;
            lines_q   <= '0;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            wr_q      <= wr_d;
            cnt_q     <= cnt_d;
            row_clr_q <= row_clr_d;
            lines_q   <= lines_d;
        end
    end

    // The write strobe is cut combinationally so an aborting reset also kills the write of its own cycle.
    assign bus.Board_we          = we_raw & Reset_n;
    assign bus.Board_waddr       = waddr;
    assign bus.Board_wdata       = wdata;
    assign bus.Board_raddr       = raddr;
    assign bus.Lock_ready        = (state_q == IDLE);
    assign bus.Clear_row         = (state_q == NOTIFY);
    assign bus.Done              = (state_q == DONE);
    assign bus.Row_to_clear      = row_clr_q;
    assign bus.Num_rows_to_clear = cnt_q;
    assign Lines_total           = lines_q;

endmodule

// File: tb/tb_row_clear_ctrl.sv
// Bench for row_clear_ctrl: board memory model, reference compaction model and
// a per-lock scoreboard of expected board, clear request, timing and line total.
module tb_row_clear_ctrl;
    import tetris_pkg::*;

    localparam int ROWS = BOARD_ROWS;
    localparam int COLS = BOARD_COLS;

    typedef logic [ROWS-1:0][COLS-1:0] board_t;
    typedef struct {
        board_t     board;
        logic [6:0] row;
        logic [3:0] num;
        int         lines;
    } exp_t;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic [15:0] Lines_total;
    int          cyc = 0;
    int          wr_cnt = 0;
    int          we_in_notify = 0;
    board_t      mem;
    board_t      load_img;
    logic        load_en;
    int          n_checks = 0;
    int          n_pass = 0;
    int          lines_exp = 0;
    exp_t        sb[$];

    row_clear_ctrl_if #(.BOARD_COLS(COLS)) bus ();

    row_clear_ctrl #(.BOARD_ROWS(ROWS), .BOARD_COLS(COLS)) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .bus         (bus),
        .Lines_total (Lines_total)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        cyc <= cyc + 1;
        if (load_en) mem <= load_img;
        else if (bus.Board_we) mem[5'(bus.Board_waddr)] <= bus.Board_wdata;
        bus.Board_rdata <= mem[5'(bus.Board_raddr)];
        if (bus.Board_we) wr_cnt <= wr_cnt + 1;
        if (bus.Board_we && bus.Clear_row) we_in_notify <= we_in_notify + 1;
    end

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    endtask

    function automatic board_t make_board(input logic [ROWS-1:0] full_mask);
        board_t b;
        for (int r = 0; r < ROWS; r++)
            b[r] = full_mask[r] ? '1 : COLS'($urandom_range(0, (1 << COLS) - 2));
        return b;
    endfunction

    function automatic exp_t model(input board_t img);
        exp_t e;
        int   dst;
        e.board = '0;
        e.row   = '0;
        e.num   = '0;
        dst     = ROWS - 1;
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (&img[r]) begin
                if (e.num == 0) e.row = 7'(r);
                e.num = e.num + 4'd1;
            end else begin
                e.board[dst] = img[r];
                dst--;
            end
        end
        e.lines = (lines_exp + int'(e.num) > 65535) ? 65535 : lines_exp + int'(e.num);
        return e;
    endfunction

    task automatic load_board(input board_t img);
        load_img = img;
        load_en  = 1'b1;
        @(negedge Clk);
        load_en  = 1'b0;
    endtask

    task automatic run_lock(input string name, input board_t img, input int ack_delay, input bit relock);
        exp_t       e;
        int         t0, w0, n0, clr_start, clr_n, done_n, done_at, post, lat_exp;
        bit         timed_out;
        logic [6:0] row_s;
        load_board(img);
        sb.push_back(model(img));
        clr_start = -1; clr_n = 0; done_n = 0; done_at = -1; post = 0;
        timed_out = 1'b1; row_s = '0;
        w0 = wr_cnt; n0 = we_in_notify; t0 = cyc;
        bus.Lock_valid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge Clk);
            bus.Lock_valid = relock && (cyc - t0 >= 5) && (cyc - t0 < 9);
            if (bus.Clear_row) begin
                if (clr_n == 0) begin
                    clr_start = cyc - t0;
                    row_s     = bus.Row_to_clear;
                end
                clr_n++;
            end
            bus.Clear_ack = bus.Clear_row && (clr_n == ack_delay);
            if (bus.Done) begin
                done_n++;
                if (done_at < 0) done_at = cyc - t0;
            end
            if (done_at >= 0) post++;
            if (post >= 25) begin
                timed_out = 1'b0;
                break;
            end
        end
        bus.Lock_valid = 1'b0;
        bus.Clear_ack  = 1'b0;
        e = sb.pop_front();
        lat_exp = (e.num == 0) ? 22 : 22 + int'(e.num) + ack_delay;
        check_eq({name, " timeout"}, timed_out, 1'b0);
        check_eq({name, " done_pulses"}, done_n, 1);
        check_eq({name, " done_latency"}, done_at, lat_exp);
        check_eq({name, " clr_start"}, clr_start, (e.num == 0) ? -1 : 22 + int'(e.num));
        check_eq({name, " clr_cycles"}, clr_n, (e.num == 0) ? 0 : ack_delay);
        if (e.num != 0) check_eq({name, " row_to_clear"}, row_s, e.row);
        check_eq({name, " num_rows"}, bus.Num_rows_to_clear, e.num);
        check_eq({name, " lines_total"}, Lines_total, e.lines);
        check_eq({name, " writes"}, wr_cnt - w0, ROWS);
        check_eq({name, " we_in_notify"}, we_in_notify - n0, 0);
        check_eq({name, " board"}, mem, e.board);
        check_eq({name, " ready_after"}, bus.Lock_ready, 1'b1);
        lines_exp = e.lines;
    endtask

    task automatic check_reset_state(input string name);
        check_eq({name, " ready"}, bus.Lock_ready, 1'b1);
        check_eq({name, " we"}, bus.Board_we, 1'b0);
        check_eq({name, " clear_row"}, bus.Clear_row, 1'b0);
        check_eq({name, " done"}, bus.Done, 1'b0);
        check_eq({name, " row_to_clear"}, bus.Row_to_clear, 7'd0);
        check_eq({name, " num_rows"}, bus.Num_rows_to_clear, 4'd0);
        check_eq({name, " lines_total"}, Lines_total, 16'd0);
        check_eq({name, " raddr"}, bus.Board_raddr, 7'd0);
        check_eq({name, " waddr"}, bus.Board_waddr, 7'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        board_t b;
        int     t0, w0;
        Reset_n        = 1'b0;
        load_en        = 1'b0;
        load_img       = '0;
        bus.Lock_valid = 1'b0;
        bus.Clear_ack  = 1'b0;
        repeat (2) @(negedge Clk);
        check_reset_state("reset");
        Reset_n = 1'b1;
        @(negedge Clk);

        run_lock("empty", '0, 2, 1'b0);

        b = make_board(20'h80000);
        b[18] = 10'h0F0;
        run_lock("bottom_row", b, 2, 1'b0);

        run_lock("gap_rows", make_board(20'h50000), 2, 1'b0);
        run_lock("tetris_slow_ack", make_board(20'hF0000), 50, 1'b0);

        bus.Clear_ack = 1'b1;
        @(negedge Clk);
        bus.Clear_ack = 1'b0;
        check_eq("idle_ack done", bus.Done, 1'b0);
        check_eq("idle_ack ready", bus.Lock_ready, 1'b1);
        run_lock("relock", make_board(20'h00402), 3, 1'b1);

        for (int t = 0; t < 3; t++) begin
            logic [ROWS-1:0] m;
            m = '0;
            for (int j = 0; j < 4; j++) m[$urandom_range(0, ROWS - 1)] = 1'b1;
            run_lock("random", make_board(m), 1 + t, 1'b0);
        end

        force dut.lines_q = 16'hFFFE;
        repeat (2) @(negedge Clk);
        release dut.lines_q;
        lines_exp = 16'hFFFE;
        run_lock("saturate4", make_board(20'h0F000), 2, 1'b0);
        run_lock("saturate1", make_board(20'h00001), 2, 1'b0);

        load_board(make_board(20'hF0000));
        t0 = cyc;
        bus.Lock_valid = 1'b1;
        @(negedge Clk);
        bus.Lock_valid = 1'b0;
        repeat (9) @(negedge Clk);
        w0 = wr_cnt;
        Reset_n = 1'b0;
        #1;
        check_eq("abort we_in_reset_cycle", bus.Board_we, 1'b0);
        @(negedge Clk);
        check_reset_state("abort");
        Reset_n = 1'b1;
        lines_exp = 0;
        repeat (3) @(negedge Clk);
        check_eq("abort writes_after", wr_cnt - w0, 0);
        check_eq("abort ready_after", bus.Lock_ready, 1'b1);
        check_eq("abort cycle_offset", cyc - t0, 14);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/row_clear_ctrl.md
ROW_CLEAR_CTRL -- requirements
Module: row_clear_ctrl

Interface
REQ-001 Parameter BOARD_ROWS, default 20, number of playfield rows (row 0 = top).
REQ-002 Parameter BOARD_COLS, default 10, cells per row.
REQ-003 Clk  input  1  single system clock; all state on posedge Clk.
REQ-004 Reset_n  input  1  synchronous, active-low reset.
REQ-005 Lock_valid  input  1  game logic reports a locked piece; board write-back complete.
REQ-006 Lock_ready  output  1  high only in IDLE; lock accepted on Lock_valid & Lock_ready.
REQ-007 Board_raddr  output  7  board row read address.
REQ-008 Board_rdata  input  BOARD_COLS  row contents; valid one cycle after Board_raddr.
REQ-009 Board_we  output  1  board row write strobe.
REQ-010 Board_waddr  output  7  board row write address.
REQ-011 Board_wdata  output  BOARD_COLS  board row write data.
REQ-012 Clear_row  output  1  renderer request; held until acknowledged.
REQ-013 Row_to_clear  output  7  largest-index (lowest) full row of this lock.
REQ-014 Num_rows_to_clear  output  4  full rows removed this lock (0..4).
REQ-015 Clear_ack  input  1  renderer finished redraw.
REQ-016 Done  output  1  one-cycle pulse at end of every accepted lock; game logic spawns next piece.
REQ-017 Lines_total  output  16  accumulated cleared rows, saturating.

Function
REQ-018 FSM states IDLE, SCAN, FILL, NOTIFY, DONE; DONE lasts exactly one cycle, then IDLE.
REQ-019 IDLE -> SCAN on accepted lock (cycle T); Lock_valid outside IDLE ignored, not queued.
REQ-020 SCAN: Board_raddr = BOARD_ROWS-1-k at cycle T+1+k, k = 0..BOARD_ROWS-1, one row per cycle.
REQ-021 Row full = Board_rdata all ones; evaluated at T+2+k.
REQ-022 Write pointer wr starts at BOARD_ROWS-1; non-full row written to wr (Board_we=1) in same cycle its data arrives, then wr decrements; full row not written, count increments, first full row seen latched as Row_to_clear.
REQ-023 Full rows need not be contiguous; compaction preserves order of surviving rows.
REQ-024 FILL: after last data (T+BOARD_ROWS+1), write all-zero rows to addresses count-1 down to 0, one per cycle; zero cycles when count = 0.
REQ-025 After FILL: count > 0 -> NOTIFY, Clear_row=1 with Row_to_clear/Num_rows_to_clear stable; count = 0 -> DONE directly, Clear_row never asserted.
REQ-026 NOTIFY -> DONE on the cycle Clear_ack=1; Clear_row drops next cycle; Clear_ack outside NOTIFY ignored.
REQ-027 Lines_total += count on entering NOTIFY; saturates at 16'hFFFF, no wrap.
REQ-028 Board_we low in IDLE, NOTIFY, DONE; Board_raddr/waddr/wdata 0 when not in use.
REQ-029 Row indices widened to 7 bits; count 4 bits; arithmetic unsigned, no pointer wrap below 0.

Reset
REQ-030 Reset_n=0 at posedge: state IDLE, Lock_ready=1 next cycle, Board_we=0, Clear_row=0, Done=0, Row_to_clear=0, Num_rows_to_clear=0, Lines_total=0, pointers/count 0.
REQ-031 Reset mid-SCAN/FILL aborts immediately; no board write in or after the reset cycle; partial board content is game logic's concern.

Structure
REQ-032 Shared package tetris_pkg holds BOARD_ROWS, BOARD_COLS, row-index width (7), FSM state enum.
REQ-033 One sub-module, row_full_detect: combinational all-ones check of a BOARD_COLS row.

Verification
REQ-034 Empty board, lock at T -> no Clear_row, Done pulse at T+22, 20 writes of unchanged rows, Lines_total 0.
REQ-035 Row 19 full, row 18 = 10'h0F0 -> row 19 = 10'h0F0, rows shifted down 1, row 0 = 0; Row_to_clear 19, Num 1; Lines_total 1.
REQ-036 Rows 18 and 16 full (non-contiguous) -> Row_to_clear 18, Num 2, rows 17/15 land at 19-relative order, rows 0-1 zero.
REQ-037 Rows 16-19 full, Clear_ack delayed 50 cycles -> Clear_row held 50 cycles, Done one cycle after ack, Lines_total +4.
REQ-038 Lock_valid re-asserted during SCAN, Clear_ack pulsed in IDLE -> both ignored; exactly one Done.
REQ-039 Reset_n low at T+10 -> Board_we 0 from that cycle, IDLE, all outputs at REQ-030 values; Lines_total preset 16'hFFFE plus 4-row clear -> 16'hFFFF.
